uart_response_frame_builder: RTL and testbench

UART_RESPONSE_FRAME_BUILDER -- requirements
Module: uart_response_frame_builder

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/uart_response_frame_builder_if.sv | 41 ++++
 rtl/uart_response_frame_builder_crc8.sv | 27 ++
 rtl/uart_response_frame_builder.sv | 179 +++++++++++++++++
 tb/tb_uart_response_frame_builder.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Constants and state type shared by the UART request parser
//               and the response frame builder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] RESP_SOF       = 8'h5A;
    localparam logic [7:0] CRC8_POLY      = 8'h07;
    localparam logic [7:0] STATUS_LEN_ERR = 8'h82;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_STATUS = 3'd2,
        ST_CMD    = 3'd3,
        ST_ADDR   = 3'd4,
        ST_DATA   = 3'd5,
        ST_CRC    = 3'd6,
        ST_DONE   = 3'd7
    } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_response_frame_builder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_response_frame_builder_if
// Description : Request, read-data and TX FIFO signals of the response builder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_response_frame_builder_if;

    logic        build_start;
    logic [7:0]  resp_status;
    logic [7:0]  resp_cmd;
    logic [31:0] resp_addr;
    logic [6:0]  resp_data_count;
    logic        data_in_valid;
    logic [7:0]  data_in;
    logic        data_in_ready;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_data;
    logic        busy;
    logic        build_done;
    logic [15:0] frame_count;

    // Builder side
    modport master (
        input  build_start, resp_status, resp_cmd, resp_addr, resp_data_count,
        input  data_in_valid, data_in, tx_fifo_full,
        output data_in_ready, tx_fifo_wr_en, tx_fifo_data, busy, build_done,
        output frame_count
    );

    // Requester / data source / FIFO side
    modport slave (
        output build_start, resp_status, resp_cmd, resp_addr, resp_data_count,
        output data_in_valid, data_in, tx_fifo_full,
        input  data_in_ready, tx_fifo_wr_en, tx_fifo_data, busy, build_done,
        input  frame_count
    );

endinterface
`default_nettype wire

// File: rtl/uart_response_frame_builder_crc8.sv
`default_nettype none
// ============================================================================
// Module      : crc8_byte_update
// Description : Combinational CRC-8 (poly 0x07, MSB first) single-byte update.
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_byte_update
    import uart_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_w;

    always_comb begin
        crc_w = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            crc_w = crc_w[7] ? ((crc_w << 1) ^ CRC8_POLY) : (crc_w << 1);
        end
    end

    assign crc_out = crc_w;

endmodule
`default_nettype wire

// File: rtl/uart_response_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : uart_response_frame_builder
// Description : Serialises a response frame (SOF, status, cmd, [addr], [data],
//               CRC-8) into the TX FIFO. Macro RESP_ADDR_ECHO_EN adds the
//               four address bytes after CMD.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_response_frame_builder
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_DATA_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_response_frame_builder_if.master bus
);

    frame_state_e state_q;
    frame_state_e state_d;
    frame_state_e after_hdr_w;

    logic [7:0]  status_q;
    logic [7:0]  cmd_q;
    logic [6:0]  remain_q;
    logic        incl_data_q;
    logic [7:0]  crc_q;
    logic [7:0]  crc_d;
    logic [7:0]  crc_next_w;
    logic [15:0] frame_count_q;

    logic [7:0]  byte_w;
    logic        emit_w;
    logic        wr_w;
    logic        ready_w;
    logic        start_w;
    logic        len_err_w;
    logic        crc_upd_w;

    assign start_w     = (state_q == ST_IDLE) & bus.build_start;
    assign len_err_w   = 32'(bus.resp_data_count) > MAX_DATA_BYTES;
    assign after_hdr_w = incl_data_q ? ST_DATA : ST_CRC;

`ifdef RESP_ADDR_ECHO_EN
    logic [31:0] addr_q;
    logic [1:0]  addr_idx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= 32'h0;
            addr_idx_q <= 2'd0;
        end else begin
            if (start_w) begin
                addr_q     <= bus.resp_addr;
                addr_idx_q <= 2'd0;
            end else if (state_q == ST_ADDR && wr_w) begin
                addr_idx_q <= addr_idx_q + 2'd1;
            end
        end
    end
`else
    logic addr_unused;
    assign addr_unused = ^bus.resp_addr;
`endif

    always_comb begin
        state_d = state_q;
        emit_w  = 1'b0;
        byte_w  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (bus.build_start) state_d = ST_SOF;
            end
            ST_SOF: begin
                emit_w = 1'b1;
                byte_w = RESP_SOF;
                if (!bus.tx_fifo_full) state_d = ST_STATUS;
            end
            ST_STATUS: begin
                emit_w = 1'b1;
                byte_w = status_q;
                if (!bus.tx_fifo_full) state_d = ST_CMD;
            end
            ST_CMD: begin
                emit_w = 1'b1;
                byte_w = cmd_q;
`ifdef RESP_ADDR_ECHO_EN
                if (!bus.tx_fifo_full) state_d = ST_ADDR;
`else
                if (!bus.tx_fifo_full) state_d = after_hdr_w;
`endif
            end
`ifdef RESP_ADDR_ECHO_EN
            ST_ADDR: begin
                emit_w = 1'b1;
                byte_w = addr_q[{addr_idx_q, 3'b000} +: 8];
                if (!bus.tx_fifo_full && addr_idx_q == 2'd3) state_d = after_hdr_w;
            end
`endif
            ST_DATA: begin
                // Read data streams straight through; a missing byte just stalls.
                emit_w = bus.data_in_valid;
                byte_w = bus.data_in;
                if (bus.data_in_valid && !bus.tx_fifo_full && remain_q == 7'd1) begin
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                emit_w = 1'b1;
                byte_w = crc_q;
                if (!bus.tx_fifo_full) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are gated by rst so a reset cycle never writes or consumes.
    assign wr_w      = rst & emit_w & ~bus.tx_fifo_full;
    assign ready_w   = rst & (state_q == ST_DATA) & bus.data_in_valid & ~bus.tx_fifo_full;
    assign crc_upd_w = wr_w & (state_q != ST_SOF) & (state_q != ST_CRC);

    crc8_byte_update u_crc8 (
        .crc_in  (crc_q),
        .byte_in (byte_w),
        .crc_out (crc_next_w)
    );

    always_comb begin
        crc_d = crc_q;
        if (start_w) begin
            crc_d = 8'h00;
        end else if (crc_upd_w) begin
            crc_d = crc_next_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            status_q      <= 8'h00;
            cmd_q         <= 8'h00;
            remain_q      <= 7'd0;
            incl_data_q   <= 1'b0;
            crc_q         <= 8'h00;
            frame_count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            if (start_w) begin
                // An oversized request reports a length error and carries no data.
                status_q    <= len_err_w ? STATUS_LEN_ERR : bus.resp_status;
                cmd_q       <= bus.resp_cmd;
                remain_q    <= bus.resp_data_count;
                incl_data_q <= ~len_err_w & bus.resp_cmd[7] &
                               (bus.resp_status == 8'h00) &
                               (bus.resp_data_count != 7'd0);
            end else if (ready_w) begin
                remain_q <= remain_q - 7'd1;
            end
            if (state_q == ST_DONE) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign bus.tx_fifo_wr_en = wr_w;
    assign bus.tx_fifo_data  = byte_w;
    assign bus.data_in_ready = ready_w;
    assign bus.busy          = rst & (state_q != ST_IDLE);
    assign bus.build_done    = rst & (state_q == ST_DONE);
    assign bus.frame_count   = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_response_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_response_frame_builder
// Description : Self-checking bench for the response frame builder against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_response_frame_builder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fc_model = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] data_src[$];
    logic [7:0] held_q[$];
    int         got_cyc[$];
    int         exp_ndata;
    int         ready_cnt, done_cnt, done_cyc, wr_when_full, after_busy;
    bit         timeout;

`ifdef RESP_ADDR_ECHO_EN
    localparam int HDR = 7;
`else
    localparam int HDR = 3;
`endif

    uart_response_frame_builder_if bus ();

    uart_response_frame_builder #(.MAX_DATA_BYTES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // CRC-8 as the remainder of (message * x^8) mod (x^8 + x^2 + x + 1).
    function automatic logic [7:0] crc_ref(input int n);
        logic [7:0] r;
        logic       top;
        logic [7:0] b;
        r = 8'h00;
        for (int k = 0; k < n + 1; k++) begin
            b = (k < n) ? exp_q[k + 1] : 8'h00;
            for (int j = 7; j >= 0; j--) begin
                top = r[7];
                r   = {r[6:0], b[j]};
                if (top) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    // Expected frame: 5A, status, cmd, [addr LSB first], [data], crc.
    task automatic build_expected(input logic [7:0] st, input logic [7:0] cmd,
                                  input logic [31:0] addr, input int cnt);
        logic [7:0] st_eff;
        st_eff = (cnt > 64) ? 8'h82 : st;
        exp_q = {};
        exp_q.push_back(8'h5A);
        exp_q.push_back(st_eff);
        exp_q.push_back(cmd);
        for (int i = 0; i < 4; i++) if (HDR == 7) exp_q.push_back(addr[8*i +: 8]);
        exp_ndata = (cmd[7] && st_eff == 8'h00 && cnt > 0) ? cnt : 0;
        for (int i = 0; i < exp_ndata; i++) exp_q.push_back(data_src[i]);
        exp_q.push_back(crc_ref(exp_q.size() - 1));
    endtask

    task automatic idle_inputs();
        bus.build_start     = 1'b0;
        bus.data_in_valid   = 1'b0;
        bus.data_in         = 8'h00;
        bus.tx_fifo_full    = 1'b0;
    endtask

    // Drives one request and records everything the DUT emits until build_done.
    task automatic run_frame(input logic [7:0] st, input logic [7:0] cmd,
                             input logic [31:0] addr, input logic [6:0] cnt,
                             input int full_pct, input int valid_pct,
                             input int stall_at, input int stall_len, input bit restart_mid);
        int idx = 0;
        int cyc = 0;
        int stall_left = stall_len;
        bit stalling;
        bit fin = 0;
        got_q = {}; got_cyc = {}; held_q = {};
        ready_cnt = 0; done_cnt = 0; done_cyc = -1; wr_when_full = 0;
        @(negedge clk);
        bus.build_start = 1'b1;
        bus.resp_status = st; bus.resp_cmd = cmd;
        bus.resp_addr = addr; bus.resp_data_count = cnt;
        @(negedge clk);
        bus.resp_status = 8'($urandom); bus.resp_cmd = 8'($urandom);
        bus.resp_addr = $urandom; bus.resp_data_count = 7'($urandom);
        while (!fin && cyc < 3000) begin
            bus.build_start = restart_mid && (cyc == 3);
            stalling = (stall_left > 0) && (got_q.size() == stall_at);
            if (stalling) begin
                bus.tx_fifo_full = 1'b1;
                stall_left--;
            end else begin
                bus.tx_fifo_full = ($urandom_range(0, 99) < full_pct);
            end
            bus.data_in_valid = (idx < data_src.size()) && ($urandom_range(0, 99) < valid_pct);
            bus.data_in = (idx < data_src.size()) ? data_src[idx] : 8'($urandom);
            #1;
            if (bus.tx_fifo_wr_en) begin
                got_q.push_back(bus.tx_fifo_data);
                got_cyc.push_back(cyc);
                if (bus.tx_fifo_full) wr_when_full++;
            end
            if (stalling) held_q.push_back(bus.tx_fifo_data);
            if (bus.data_in_ready) begin
                ready_cnt++;
                idx++;
            end
            if (bus.build_done) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1;
            end
            cyc++;
            @(negedge clk);
        end
        timeout = !fin;
        idle_inputs();
        #1;
        after_busy = int'(bus.busy) + int'(bus.build_done);
        if (fin) fc_model = (fc_model + 1) & 16'hFFFF;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        checks++; if (bus.tx_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, expected 0", bus.tx_fifo_wr_en); end
        checks++; if (bus.data_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", bus.data_in_ready); end
        checks++; if (bus.build_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", bus.build_done); end
        checks++; if (bus.frame_count !== 16'h0) begin errors++; $display("FAIL reset_fc: got %h, expected 0000", bus.frame_count); end
        rst = 1'b1;
        fc_model = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int idx = 0;
        int bad = 0;
        @(negedge clk);
        bus.build_start = 1'b1; bus.resp_status = 8'h00; bus.resp_cmd = 8'hA0;
        bus.resp_addr = 32'h0; bus.resp_data_count = 7'd4;
        @(negedge clk);
        bus.build_start = 1'b0;
        bus.data_in_valid = 1'b1;
        for (int cyc = 0; cyc < 50 && idx < 2; cyc++) begin
            bus.data_in = d[idx];
            #1;
            if (bus.data_in_ready) idx++;
            @(negedge clk);
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL rstmid_two_bytes: consumed %0d, expected 2", idx); end
        bus.data_in = d[2];
        rst = 1'b0;
        #1;
        checks++; if (bus.tx_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_in_reset: got %b, expected 0", bus.tx_fifo_wr_en); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy %b, expected 0", bus.busy); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (bus.tx_fifo_wr_en || bus.data_in_ready || bus.build_done) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_activity: %0d active cycles, expected 0", bad); end
        checks++; if (bus.frame_count !== 16'h0) begin errors++; $display("FAIL rstmid_fc: got %h, expected 0000", bus.frame_count); end
        idle_inputs();
        fc_model = 0;
    endtask

    task automatic test_write_ack();
        logic [7:0] lit[4] = '{8'h5A, 8'h00, 8'h20, 8'hE0};
        logic [31:0] a = $urandom;
        data_src = {};
        build_expected(8'h00, 8'h20, a, 0);
        run_frame(8'h00, 8'h20, a, 7'd0, 0, 100, -1, 0, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL ack_timeout: no build_done within budget"); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ack_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ack_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
            checks++;
            if (got_cyc[i] !== i) begin errors++; $display("FAIL ack_cycle%0d: written at %0d, expected %0d", i, got_cyc[i], i); end
        end
        if (HDR == 3 && got_q.size() == 4) begin
            foreach (lit[i]) begin
                checks++;
                if (got_q[i] !== lit[i]) begin errors++; $display("FAIL ack_literal%0d: got %h, expected %h", i, got_q[i], lit[i]); end
            end
        end
        checks++; if (done_cyc !== exp_q.size()) begin errors++; $display("FAIL ack_done_cycle: got %0d, expected %0d", done_cyc, exp_q.size()); end
        checks++; if (after_busy !== 0) begin errors++; $display("FAIL ack_after: busy+done %0d, expected 0", after_busy); end
        checks++; if (bus.frame_count !== 16'(fc_model)) begin errors++; $display("FAIL ack_fc: got %0d, expected %0d", bus.frame_count, fc_model); end
    endtask

    task automatic test_read();
        logic [31:0] a = $urandom;
        data_src = {8'h11, 8'h22, 8'h33, 8'h44};
        build_expected(8'h00, 8'hA0, a, 4);
        run_frame(8'h00, 8'hA0, a, 7'd4, 0, 100, -1, 0, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL read_timeout: no build_done within budget"); end
        checks++; if (ready_cnt !== 4) begin errors++; $display("FAIL read_ready_pulses: got %0d, expected 4", ready_cnt); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL read_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL read_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[HDR + i] !== data_src[i]) begin errors++; $display("FAIL read_data%0d: got %h, expected %h", i, got_q[HDR + i], data_src[i]); end
            end
        end
        checks++; if (bus.frame_count !== 16'(fc_model)) begin errors++; $display("FAIL read_fc: got %0d, expected %0d", bus.frame_count, fc_model); end
    endtask

    task automatic test_fifo_stall();
        logic [31:0] a = $urandom;
        data_src = {8'h5A, 8'hC3};
        build_expected(8'h00, 8'h80, a, 2);
        run_frame(8'h00, 8'h80, a, 7'd2, 0, 100, 1, 5, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL stall_timeout: no build_done within budget"); end
        checks++; if (held_q.size() !== 5) begin errors++; $display("FAIL stall_cycles: got %0d, expected 5", held_q.size()); end
        foreach (held_q[i]) begin
            checks++;
            if (held_q[i] !== 8'h00) begin errors++; $display("FAIL stall_hold%0d: data %h, expected 00", i, held_q[i]); end
        end
        checks++; if (wr_when_full !== 0) begin errors++; $display("FAIL stall_wr_when_full: got %0d, expected 0", wr_when_full); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
            end
            checks++;
            if (got_cyc[1] !== 6) begin errors++; $display("FAIL stall_resume: status written at %0d, expected 6", got_cyc[1]); end
        end
    endtask

    task automatic test_len_error();
        logic [31:0] a = $urandom;
        data_src = {};
        for (int i = 0; i < 100; i++) data_src.push_back(8'($urandom));
        build_expected(8'h00, 8'hA0, a, 100);
        run_frame(8'h00, 8'hA0, a, 7'd100, 0, 100, -1, 0, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL lenerr_timeout: no build_done within budget"); end
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL lenerr_ready: got %0d pulses, expected 0", ready_cnt); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL lenerr_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
        else begin
            checks++;
            if (got_q[1] !== 8'h82) begin errors++; $display("FAIL lenerr_status: got %h, expected 82", got_q[1]); end
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lenerr_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_addr_echo_busy();
        logic [7:0] ab[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int fc_before = fc_model;
        data_src = {};
        build_expected(8'h05, 8'h21, 32'h12345678, 0);
        run_frame(8'h05, 8'h21, 32'h12345678, 7'd0, 0, 100, -1, 0, 1'b1);
        checks++; if (timeout) begin errors++; $display("FAIL addr_timeout: no build_done within budget"); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL addr_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL addr_byte%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
            end
            if (HDR == 7) begin
                foreach (ab[i]) begin
                    checks++;
                    if (got_q[3 + i] !== ab[i]) begin errors++; $display("FAIL addr_echo%0d: got %h, expected %h", i, got_q[3 + i], ab[i]); end
                end
            end
        end
        checks++; if (after_busy !== 0) begin errors++; $display("FAIL addr_restart_ignored: busy+done %0d, expected 0", after_busy); end
        checks++; if (bus.frame_count !== 16'(fc_before + 1)) begin errors++; $display("FAIL addr_fc: got %0d, expected %0d", bus.frame_count, fc_before + 1); end
    endtask

    task automatic test_random();
        logic [7:0]  st, cmd;
        logic [31:0] a;
        logic [6:0]  cnt;
        for (int n = 0; n < 25; n++) begin
            st  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cmd = 8'($urandom);
            a   = $urandom;
            cnt = 7'($urandom_range(0, 72));
            data_src = {};
            for (int i = 0; i < int'(cnt); i++) data_src.push_back(8'($urandom));
            build_expected(st, cmd, a, int'(cnt));
            run_frame(st, cmd, a, cnt, 30, 70, -1, 0, 1'b0);
            checks++; if (timeout) begin errors++; $display("FAIL rand%0d_timeout: no build_done within budget", n); end
            checks++; if (ready_cnt !== exp_ndata) begin errors++; $display("FAIL rand%0d_ready: got %0d, expected %0d", n, ready_cnt, exp_ndata); end
            checks++; if (wr_when_full !== 0) begin errors++; $display("FAIL rand%0d_wr_full: got %0d, expected 0", n, wr_when_full); end
            checks++;
            if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d bytes, expected %0d", n, got_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h, expected %h", n, i, got_q[i], exp_q[i]); end
            end
            checks++; if (bus.frame_count !== 16'(fc_model)) begin errors++; $display("FAIL rand%0d_fc: got %0d, expected %0d", n, bus.frame_count, fc_model); end
        end
    endtask

    initial begin
        idle_inputs();
        bus.resp_status = 8'h00; bus.resp_cmd = 8'h00;
        bus.resp_addr = 32'h0; bus.resp_data_count = 7'd0;
        test_reset();
        test_reset_mid_frame();
        test_write_ack();
        test_read();
        test_fifo_stall();
        test_len_error();
        test_addr_echo_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
